clk_div_ctrl: RTL
=================

// Module: clk_div_ctrl
// PURPOSE
//   Run-time controller and generator for a programmable integer clock divider in the clk_in domain.
//   Accepts divide-ratio change requests over a valid/ready handshake.
//   Applies each change only at an output-period boundary, followed by a forced-low guard gap,
//   so the divided output never produces a runt pulse.
//   Drives a divided level (clk_lvl_out) and a once-per-period enable pulse (clk_en_out) for downstream logic.
// PARAMETERS
//   CNT_W      8  width of divide ratio and period counter; maximum ratio is 2^CNT_W-1
//   DEF_DIV    3  ratio loaded at reset; must satisfy MIN_DIV <= DEF_DIV <= 2^CNT_W-1
//   MIN_DIV    2  smallest legal ratio; must be >= 2
//   GAP_CYCLES 2  forced-low clk_in cycles inserted between old and new ratio; 0 is legal
// PORTS
//   clk_in       in   1      single clock; all logic on its rising edge
//   rst          in   1      synchronous reset, active-high
//   en           in   1      level; 1 = run divider, 0 = stop at end of current period
//   cfg_valid    in   1      ratio change request valid
//   cfg_div      in   CNT_W  requested ratio; sampled when cfg_valid & cfg_ready
//   cfg_ready    out  1      controller can accept a request (IDLE or RUN state)
//   cfg_err      out  1      1-cycle pulse: accepted request had cfg_div < MIN_DIV; request dropped
//   sw_done      out  1      1-cycle pulse in the cycle a new ratio takes effect
//   busy         out  1      1 in DRAIN, GAP or STOP
//   cur_div      out  CNT_W  ratio currently in force
//   clk_en_out   out  1      registered; 1 in the first cycle (cnt==0) of every RUN period
//   clk_lvl_out  out  1      registered; 1 while cnt < (cur_div>>1) in RUN, else 0
// BEHAVIOUR
//   Reset values (while rst is high and in the cycle after it is released):
//   - state=IDLE, cnt=0, cur_div=DEF_DIV.
//   - All outputs are 0 except cur_div.
//   - cfg_ready is 0 while rst is high, then follows state.
//   States:
//   - IDLE: outputs low.
//     - Accepted legal request loads cur_div directly and pulses sw_done in the next cycle.
//     - en=1 -> RUN. The first RUN cycle has cnt=0.
//   - RUN: cnt counts 0..cur_div-1 and wraps to 0.
//     - Accepted legal request: latch it into pend_div, go to DRAIN.
//     - en=0 (no request): go to STOP.
//   - DRAIN: counting continues unchanged. In the cycle with cnt==cur_div-1:
//     - cur_div is updated from pend_div.
//     - Go to GAP, or go to RUN/IDLE directly when GAP_CYCLES==0.
//   - GAP: cnt is held, outputs are low for exactly GAP_CYCLES cycles.
//     - Then go to RUN with cnt=0 if en=1, else go to IDLE.
//     - sw_done pulses in the first RUN (or IDLE) cycle after the change.
//   - STOP: finish the current period.
//     - In the cycle with cnt==cur_div-1, go to IDLE.
//     - en re-asserted during STOP is honoured only after IDLE is reached.
//   Output timing and handshake:
//   - Output latency is one cycle. clk_en_out and clk_lvl_out registered from cnt/state give the
//     pattern starting with the first RUN cycle, e.g. div=3 -> lvl 1,0,0.
//   - Odd ratios: low phase is one cycle longer than the high phase.
//   - cfg_ready=0 in DRAIN/GAP/STOP. cfg_valid may be held and is accepted on return to IDLE/RUN.
//   - A request with cfg_div<MIN_DIV is still handshaken: cfg_err pulses next cycle, no state or ratio change.
//   Simultaneous events:
//   - cfg accepted while en=0 in RUN: the change is applied via DRAIN/GAP, then the controller ends in IDLE.
//   - en falls during DRAIN/GAP: the change still completes, then the controller goes to IDLE.
//   Counter:
//   - cnt is CNT_W bits and compares against cur_div-1.
//   - Ratio 2^CNT_W-1 is legal. cnt never exceeds cur_div-1.
//   - Reset mid-operation discards pend_div and returns to the reset state in one cycle.
// TESTING
//   1. rst then en=1, default DEF_DIV=3 -> clk_en_out every 3 cycles; lvl 1,0,0 repeating; cur_div=3.
//   2. RUN div=3, cfg_div=4 accepted at cnt=1 -> cfg_ready=0, period completes, 2 low gap cycles,
//      then lvl 1,1,0,0 and sw_done=1 in the first new cycle; cur_div=4.
//   3. cfg_div=1 during RUN -> cfg_err 1-cycle pulse, cur_div unchanged, output pattern uninterrupted.
//   4. div=5, en=0 at cnt=1 -> three more cycles (cnt 2,3,4), then IDLE; outputs 0, busy back to 0.
//   5. Assert rst in GAP -> next cycle all outputs 0, cur_div=3, cfg_ready=0 until rst is released.
//   6. In IDLE, cfg_div=255, then en=1 -> 255-cycle period; lvl high 127 cycles, low 128 cycles.

Source files
------------

// File: rtl/clk_div_cfg_if.sv
// Ratio-change request channel for clk_div_ctrl.
// Valid/ready handshake plus a one-cycle error return.
interface clk_div_cfg_if #(
  parameter int W = 8
);
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with glitch-free ratio switching.
// Ratio changes land on a period boundary followed by a forced-low gap.
module clk_div_ctrl #(
  parameter int CNT_W      = 8,
  parameter int DEF_DIV    = 3,
  parameter int MIN_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  clk_div_cfg_if.slave     cfg,
  output logic             sw_done,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_en_out,
  output logic             clk_lvl_out
);

  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    GAP,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             done_d, err_d;
  logic             accept, legal, last, active;
  logic [CNT_W-1:0] cnt_nxt;

  assign cfg.cfg_ready = !rst &&
    (state_q == IDLE || state_q == RUN);
  assign accept  = cfg.cfg_valid && cfg.cfg_ready;
  assign legal   = cfg.cfg_div >= CNT_W'(MIN_DIV);
  assign last    = cnt_q == cur_q - CNT_W'(1);
  assign cnt_nxt = last ? '0 : cnt_q + CNT_W'(1);
  assign busy    = state_q == DRAIN || state_q == GAP ||
                   state_q == STOP;
  // Periods keep running while a change drains or a stop completes
  assign active  = state_q == RUN || state_q == DRAIN ||
                   state_q == STOP;
  assign cur_div = cur_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    err_d   = accept && !legal;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept && legal) begin
          cur_d  = cfg.cfg_div;
          done_d = 1'b1;
        end
        if (en) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_nxt;
        if (accept && legal) begin
          pend_d  = cfg.cfg_div;
          state_d = DRAIN;
        end else if (!en) begin
          state_d = last ? IDLE : STOP;
        end
      end
      DRAIN: begin
        cnt_d = cnt_nxt;
        if (last) begin
          cur_d = pend_q;
          gap_d = '0;
          if (GAP_CYCLES == 0) begin
            done_d  = 1'b1;
            state_d = en ? RUN : IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) begin
          done_d  = 1'b1;
          state_d = en ? RUN : IDLE;
        end
      end
      STOP: begin
        cnt_d = cnt_nxt;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= CNT_W'(DEF_DIV);
      pend_q      <= CNT_W'(DEF_DIV);
      gap_q       <= '0;
      sw_done     <= 1'b0;
      cfg.cfg_err <= 1'b0;
      clk_en_out  <= 1'b0;
      clk_lvl_out <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      gap_q       <= gap_d;
      sw_done     <= done_d;
      cfg.cfg_err <= err_d;
      clk_en_out  <= active && cnt_q == '0;
      clk_lvl_out <= active && cnt_q < (cur_q >> 1);
    end
  end

endmodule
